// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: sequencing
// states, the hardwired-zero register number and default mult/div latencies.
package mips_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MD_BUSY  = 2'd2
   } hz_state_e;

   localparam logic [4:0]  REG_ZERO       = 5'd0;
   localparam int unsigned MUL_CYCLES_DEF = 4;
   localparam int unsigned DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/muldiv_busy_timer.sv
// Occupancy timer for the multi-cycle mult/div unit: loads the operation
// length minus one on launch and counts down to zero; busy while nonzero.
module muldiv_busy_timer
   import mips_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W      = 6
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic is_div_i,
   output logic busy_o,
   output logic last_o
);

   localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A launch while still busy reloads rather than queueing.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = is_div_i ? DIV_LD : MUL_LD;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign busy_o = (cnt_q != '0);
   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencing: freeze, branch flush, load-use and HI/LO
// interlock stalls. Define HAZARD_PERF_CNT_EN to add stall/flush/freeze counters.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
   parameter int unsigned CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       id_reads_hilo,
   input  logic       id_is_muldiv,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   input  logic       ex_branch_taken,
   input  logic       ex_muldiv_start,
   input  logic       ex_muldiv_is_div,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       if_id_flush,
   output logic       id_ex_bubble,
   output logic       ex_mem_write,
   output logic       mem_wb_write,
   output logic       muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count,
   output logic [31:0] freeze_cycles
`endif
);

   hz_state_e state_q, state_d;
   logic      freeze, load_use, hilo_stall, md_load, md_busy, md_last;

   assign freeze     = mem_req & ~mem_ready;
   assign load_use   = ex_mem_read && (ex_rd != REG_ZERO) &&
                       ((id_rs == ex_rd) || (id_uses_rt && (id_rt == ex_rd)));
   assign hilo_stall = md_busy & (id_reads_hilo | id_is_muldiv);
   assign md_load    = ex_muldiv_start & ~freeze;

   muldiv_busy_timer #(
      .MUL_CYCLES(MUL_CYCLES),
      .DIV_CYCLES(DIV_CYCLES),
      .CNT_W     (CNT_W)
   ) u_timer (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (md_load),
      .is_div_i(ex_muldiv_is_div),
      .busy_o  (md_busy),
      .last_o  (md_last)
   );

   always_comb begin
      state_d = state_q;
      if (freeze)
         state_d = MEM_WAIT;
      else if (md_load)
         state_d = MD_BUSY;
      else begin
         case (state_q)
            MEM_WAIT, MD_BUSY: state_d = (md_busy && !md_last) ? MD_BUSY : RUN;
            default:           state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      muldiv_busy  = md_busy & ~rst;
      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
      end else if (freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (load_use || hilo_stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_q, stall_d, flush_q, flush_d, frz_q, frz_d;

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      frz_d   = frz_q;
      if (freeze)
         frz_d = frz_q + 32'd1;
      else if (ex_branch_taken)
         flush_d = flush_q + 32'd1;
      else if (load_use || hilo_stall)
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
         frz_q   <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
         frz_q   <= frz_d;
      end
   end

   assign stall_cycles  = stall_q;
   assign flush_count   = flush_q;
   assign freeze_cycles = frz_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output vectors are queued as
// stimulus is applied and popped at the following negedge for comparison.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rd;
   logic       id_uses_rt, id_reads_hilo, id_is_muldiv;
   logic       ex_mem_read, ex_branch_taken, ex_muldiv_start, ex_muldiv_is_div;
   logic       mem_req, mem_ready;
   logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
   logic       ex_mem_write, mem_wb_write, muldiv_busy;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count, freeze_cycles;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [6:0]  exp_q[$];
   logic [6:0]  e;
   logic [6:0]  obs;

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_write, muldiv_busy}
   localparam logic [6:0] V_RST   = 7'b0011000;
   localparam logic [6:0] V_RUN   = 7'b1100110;
   localparam logic [6:0] V_STALL = 7'b0001110;
   localparam logic [6:0] V_FLUSH = 7'b1111110;
   localparam logic [6:0] V_FRZ   = 7'b0000000;

   assign obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                 ex_mem_write, mem_wb_write, muldiv_busy};

   always #5 clk = ~clk;

   hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .id_reads_hilo   (id_reads_hilo),
      .id_is_muldiv    (id_is_muldiv),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .ex_muldiv_start (ex_muldiv_start),
      .ex_muldiv_is_div(ex_muldiv_is_div),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_bubble    (id_ex_bubble),
      .ex_mem_write    (ex_mem_write),
      .mem_wb_write    (mem_wb_write),
      .muldiv_busy     (muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count),
      .freeze_cycles   (freeze_cycles)
`endif
   );

   task automatic idle_inputs();
      rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
      id_uses_rt = 1'b0; id_reads_hilo = 1'b0; id_is_muldiv = 1'b0;
      ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0;
      ex_muldiv_is_div = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      next_cycle(); rst = 1'b1; exp_q.push_back(V_RST);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_hold got=%b exp=%b", obs, e); end
      next_cycle(); exp_q.push_back(V_RUN);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_release got=%b exp=%b", obs, e); end
   endtask

   task automatic test_load_use();
      // rows: ex_mem_read, ex_rd, id_rs, id_rt, id_uses_rt, expected
      logic [6:0] exv [6];
      logic [4:0] rdv [6], rsv [6], rtv [6];
      logic       lv [6], uv [6];
      lv = '{1, 0, 1, 1, 1, 1}; rdv = '{8, 0, 0, 9, 9, 8};
      rsv = '{8, 8, 0, 3, 3, 7}; rtv = '{0, 0, 0, 9, 9, 8}; uv = '{0, 0, 0, 1, 0, 1};
      exv = '{V_STALL, V_RUN, V_RUN, V_STALL, V_RUN, V_STALL};
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         ex_mem_read = lv[i]; ex_rd = rdv[i]; id_rs = rsv[i]; id_rt = rtv[i]; id_uses_rt = uv[i];
         exp_q.push_back(exv[i]);
         @(negedge clk); e = exp_q.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL load_use[%0d] got=%b exp=%b", i, obs, e); end
      end
   endtask

   task automatic test_branch_priority();
      next_cycle();
      ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
      exp_q.push_back(V_FLUSH);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL branch_over_loaduse got=%b exp=%b", obs, e); end
   endtask

   task automatic test_muldiv(input logic is_div, input int unsigned n_busy);
      next_cycle();
      ex_muldiv_start = 1'b1; ex_muldiv_is_div = is_div;
      exp_q.push_back(V_RUN);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL md_start got=%b exp=%b", obs, e); end
      for (int unsigned k = 0; k <= n_busy; k++) begin
         next_cycle();
         if (is_div) id_is_muldiv = 1'b1; else id_reads_hilo = 1'b1;
         exp_q.push_back(k < n_busy ? (V_STALL | 7'b0000001) : V_RUN);
         @(negedge clk); e = exp_q.pop_front(); checks++;
         if (obs !== e) begin
            errors++; $display("FAIL md_interlock div=%0d k=%0d got=%b exp=%b", is_div, k, obs, e);
         end
      end
   endtask

   task automatic test_freeze();
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         ex_branch_taken = 1'b1; mem_req = 1'b1; mem_ready = (k == 3);
         exp_q.push_back(k == 3 ? V_FLUSH : V_FRZ);
         @(negedge clk); e = exp_q.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL freeze_branch k=%0d got=%b exp=%b", k, obs, e); end
      end
      // a launch during a freeze is ignored, so no busy afterwards
      next_cycle(); ex_muldiv_start = 1'b1; mem_req = 1'b1; exp_q.push_back(V_FRZ);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL freeze_start got=%b exp=%b", obs, e); end
      next_cycle(); id_reads_hilo = 1'b1; exp_q.push_back(V_RUN);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL freeze_start_after got=%b exp=%b", obs, e); end
      // busy count keeps draining while frozen
      next_cycle(); ex_muldiv_start = 1'b1; exp_q.push_back(V_RUN);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL frz_md_start got=%b exp=%b", obs, e); end
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         id_reads_hilo = 1'b1; mem_req = (k < 3); mem_ready = 1'b0;
         exp_q.push_back(k < 3 ? 7'b0000001 : V_RUN);
         @(negedge clk); e = exp_q.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL frz_md_drain k=%0d got=%b exp=%b", k, obs, e); end
      end
   endtask

   task automatic test_reset_mid_div();
      next_cycle(); ex_muldiv_start = 1'b1; ex_muldiv_is_div = 1'b1; exp_q.push_back(V_RUN);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rdiv_start got=%b exp=%b", obs, e); end
      for (int k = 1; k <= 22; k++) begin
         next_cycle();
         rst = (k == 22);
         exp_q.push_back(k == 22 ? V_RST : (V_RUN | 7'b0000001));
         @(negedge clk); e = exp_q.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL rdiv k=%0d got=%b exp=%b", k, obs, e); end
      end
      next_cycle(); id_reads_hilo = 1'b1; exp_q.push_back(V_RUN);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rdiv_after got=%b exp=%b", obs, e); end
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf();
      logic [95:0] pe;
      next_cycle(); rst = 1'b1;
      next_cycle(); ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
      next_cycle(); ex_branch_taken = 1'b1;
      next_cycle(); mem_req = 1'b1;
      next_cycle(); mem_req = 1'b1;
      next_cycle();
      pe = {32'd1, 32'd1, 32'd2};
      @(negedge clk); checks++;
      if ({stall_cycles, flush_count, freeze_cycles} !== pe) begin
         errors++;
         $display("FAIL perf_counts got=%0d/%0d/%0d exp=1/1/2", stall_cycles, flush_count, freeze_cycles);
      end
      next_cycle(); rst = 1'b1;
      @(negedge clk);
      next_cycle();
      @(negedge clk); checks++;
      if ({stall_cycles, flush_count, freeze_cycles} !== 96'd0) begin
         errors++;
         $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", stall_cycles, flush_count, freeze_cycles);
      end
   endtask
`endif

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_load_use();
      test_branch_priority();
      test_muldiv(1'b0, 3);
      test_muldiv(1'b1, 31);
      test_freeze();
      test_reset_mid_div();
`ifdef HAZARD_PERF_CNT_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
